vga_pattern_sequencer: RTL and testbench

VGA_PATTERN_SEQUENCER -- requirements
Module: vga_pattern_sequencer

---
 rtl/vga_pattern_sequencer.sv | 171 +++++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer.sv
// Chooses the VGA test pattern, either from the manual switch or by timed auto-cycling, updating only at frame start.
// Optional input debounce on the synchronized controls is enabled by defining SEQ_DEBOUNCE_EN.
module vga_pattern_sequencer #(
   parameter int HOLD_FRAMES = 60,
   parameter int DEB_CYCLES  = 1000
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic [1:0] switch,
   input  logic       auto_en,
   input  logic       pause,
   output logic [1:0] pattern_sel,
   output logic [1:0] seq_state,
   output logic       sel_changed
);

   if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_hold_range
      $error("HOLD_FRAMES out of range 1..255");
   end
   if (DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_deb_range
      $error("DEB_CYCLES out of range 1..65535");
   end

   typedef enum logic [1:0] {MANUAL = 2'd0, AUTO = 2'd1, PAUSED = 2'd2} state_e;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

   logic [1:0] sw_s1_q, sw_s2_q;
   logic       auto_s1_q, auto_s2_q;
   logic       pause_s1_q, pause_s2_q;
   logic [1:0] sw_f;
   logic       auto_f, pause_f;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         auto_s1_q  <= 1'b0;
         auto_s2_q  <= 1'b0;
         pause_s1_q <= 1'b0;
         pause_s2_q <= 1'b0;
      end else begin
         sw_s1_q    <= switch;
         sw_s2_q    <= sw_s1_q;
         auto_s1_q  <= auto_en;
         auto_s2_q  <= auto_s1_q;
         pause_s1_q <= pause;
         pause_s2_q <= pause_s1_q;
      end
   end

`ifdef SEQ_DEBOUNCE_EN
   localparam logic [15:0] DEB_N = 16'(DEB_CYCLES);

   logic [1:0]  sw_f_q, sw_last_q;
   logic        auto_f_q, auto_last_q, pause_f_q, pause_last_q;
   logic [15:0] sw_cnt_q, auto_cnt_q, pause_cnt_q;
   logic [15:0] sw_cnt_d, auto_cnt_d, pause_cnt_d;

   // Counts consecutive cycles the synchronized value has differed from the filtered one without moving.
   function automatic logic [15:0] deb_count(input logic differs, input logic moved,
                                             input logic [15:0] cnt);
      if (!differs)   return 16'd0;
      else if (moved) return 16'd1;
      else            return cnt + 16'd1;
   endfunction

   always_comb begin
      sw_cnt_d    = deb_count(sw_s2_q != sw_f_q, sw_s2_q != sw_last_q, sw_cnt_q);
      auto_cnt_d  = deb_count(auto_s2_q != auto_f_q, auto_s2_q != auto_last_q, auto_cnt_q);
      pause_cnt_d = deb_count(pause_s2_q != pause_f_q, pause_s2_q != pause_last_q, pause_cnt_q);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sw_f_q       <= '0;
         sw_last_q    <= '0;
         sw_cnt_q     <= '0;
         auto_f_q     <= 1'b0;
         auto_last_q  <= 1'b0;
         auto_cnt_q   <= '0;
         pause_f_q    <= 1'b0;
         pause_last_q <= 1'b0;
         pause_cnt_q  <= '0;
      end else begin
         sw_last_q    <= sw_s2_q;
         auto_last_q  <= auto_s2_q;
         pause_last_q <= pause_s2_q;
         if (sw_cnt_d == DEB_N) begin
            sw_f_q   <= sw_s2_q;
            sw_cnt_q <= '0;
         end else begin
            sw_cnt_q <= sw_cnt_d;
         end
         if (auto_cnt_d == DEB_N) begin
            auto_f_q   <= auto_s2_q;
            auto_cnt_q <= '0;
         end else begin
            auto_cnt_q <= auto_cnt_d;
         end
         if (pause_cnt_d == DEB_N) begin
            pause_f_q   <= pause_s2_q;
            pause_cnt_q <= '0;
         end else begin
            pause_cnt_q <= pause_cnt_d;
         end
      end
   end

   assign sw_f    = sw_f_q;
   assign auto_f  = auto_f_q;
   assign pause_f = pause_f_q;
`else
   assign sw_f    = sw_s2_q;
   assign auto_f  = auto_s2_q;
   assign pause_f = pause_s2_q;
`endif

   state_e     state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [1:0] sel_q, sel_d, sel_prev_q;
   logic       sel_changed_q;

   // Tick action is keyed on state_q, so a transition on the same edge only affects later ticks.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      sel_d       = sel_q;
      case (state_q)
         MANUAL:  if (auto_f) state_d = AUTO;
         AUTO:    if (!auto_f) state_d = MANUAL; else if (pause_f) state_d = PAUSED;
         PAUSED:  if (!auto_f) state_d = MANUAL; else if (!pause_f) state_d = AUTO;
         default: state_d = MANUAL;
      endcase
      if (frame_tick) begin
         if (state_q == MANUAL) begin
            sel_d = sw_f;
         end else if (state_q == AUTO) begin
            if (frame_cnt_q == HOLD_LAST) begin
               frame_cnt_d = '0;
               sel_d       = sel_q + 2'd1;
            end else begin
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
      end
      if (state_q == MANUAL || state_d == MANUAL) frame_cnt_d = '0;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= MANUAL;
         frame_cnt_q   <= '0;
         sel_q         <= '0;
         sel_prev_q    <= '0;
         sel_changed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         sel_q         <= sel_d;
         sel_prev_q    <= sel_q;
         sel_changed_q <= (sel_q != sel_prev_q);
      end
   end

   assign pattern_sel = sel_q;
   assign seq_state   = state_q;
   assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer: a per-frame vector table plus hand-written timing corner cases.
module tb_vga_pattern_sequencer;
   localparam int HOLD = 2;
   localparam int DEB  = 4;
`ifdef SEQ_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
`else
   localparam int LAT = 2;
`endif
   localparam int IDLE = 10;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic [1:0] switch;
   logic       auto_en;
   logic       pause;
   logic [1:0] pattern_sel;
   logic [1:0] seq_state;
   logic       sel_changed;

   vga_pattern_sequencer #(.HOLD_FRAMES(HOLD), .DEB_CYCLES(DEB)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .switch      (switch),
      .auto_en     (auto_en),
      .pause       (pause),
      .pattern_sel (pattern_sel),
      .seq_state   (seq_state),
      .sel_changed (sel_changed)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] sw;
      logic       au;
      logic       pa;
      logic [1:0] exp_sel;
      logic [1:0] exp_st;
      logic       exp_chg;
   } vec_t;

   vec_t vecs[17];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Settle inputs, then one frame_tick; check outputs after the tick edge and sel_changed one cycle later.
   task automatic run_frame(input logic [1:0] sw, input logic au, input logic pa,
                            input logic [1:0] e_sel, input logic [1:0] e_st, input logic e_chg,
                            input string name);
      @(negedge clock);
      switch = sw; auto_en = au; pause = pa; frame_tick = 1'b0;
      repeat (IDLE) @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      chk({name, ".sel"}, 8'(pattern_sel), 8'(e_sel));
      chk({name, ".state"}, 8'(seq_state), 8'(e_st));
      @(negedge clock);
      chk({name, ".chg"}, 8'(sel_changed), 8'(e_chg));
   endtask

   initial begin
      logic bad;
      vecs[0]  = '{2'd3, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1};
      vecs[1]  = '{2'd3, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0};
      vecs[2]  = '{2'd1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1};
      vecs[3]  = '{2'd1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0};
      vecs[4]  = '{2'd1, 1'b1, 1'b0, 2'd2, 2'd1, 1'b1};
      vecs[5]  = '{2'd1, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0};
      vecs[6]  = '{2'd1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1};
      vecs[7]  = '{2'd1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b0};
      vecs[8]  = '{2'd1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1};
      vecs[9]  = '{2'd1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0};
      vecs[10] = '{2'd1, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
      vecs[11] = '{2'd1, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
      vecs[12] = '{2'd1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1};
      vecs[13] = '{2'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1};
      vecs[14] = '{2'd2, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0};
      vecs[15] = '{2'd2, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0};
      vecs[16] = '{2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};

      rst_n = 1'b0; switch = '0; auto_en = 1'b0; pause = 1'b0; frame_tick = 1'b0;
      #12;
      chk("reset.sel", 8'(pattern_sel), 8'd0);
      chk("reset.state", 8'(seq_state), 8'd0);
      chk("reset.chg", 8'(sel_changed), 8'd0);
      @(negedge clock);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++)
         run_frame(vecs[i].sw, vecs[i].au, vecs[i].pa, vecs[i].exp_sel, vecs[i].exp_st,
                   vecs[i].exp_chg, $sformatf("v%0d", i));

      // Switch activity between ticks must never reach pattern_sel.
      run_frame(2'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, "sw2");
      bad = 1'b0;
      @(negedge clock); switch = 2'd1;
      repeat (3) begin @(negedge clock); if (pattern_sel !== 2'd2) bad = 1'b1; end
      switch = 2'd3;
      repeat (3) begin @(negedge clock); if (pattern_sel !== 2'd2) bad = 1'b1; end
      switch = 2'd2;
      repeat (IDLE) begin @(negedge clock); if (pattern_sel !== 2'd2) bad = 1'b1; end
      chk("no_tick_hold", 8'(bad), 8'd0);
      run_frame(2'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, "reload_eq");

      // Back-to-back ticks straddling the edge where the new switch value becomes visible.
      @(negedge clock); switch = 2'd1;
      repeat (LAT - 1) @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      chk("tick_a.sel", 8'(pattern_sel), 8'd2);
      @(negedge clock);
      frame_tick = 1'b0;
      chk("tick_b.sel", 8'(pattern_sel), 8'd1);
      chk("tick_b.chg", 8'(sel_changed), 8'd0);
      @(negedge clock);
      chk("tick_b.chg_next", 8'(sel_changed), 8'd1);

      // Asynchronous reset in the middle of a frame while in AUTO with pattern 2.
      run_frame(2'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, "pre_rst");
      @(negedge clock); auto_en = 1'b1;
      repeat (IDLE) @(negedge clock);
      chk("pre_rst.state", 8'(seq_state), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async.sel", 8'(pattern_sel), 8'd0);
      chk("rst_async.state", 8'(seq_state), 8'd0);
      chk("rst_async.chg", 8'(sel_changed), 8'd0);
      @(negedge clock);
      rst_n = 1'b1;
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      chk("post_rst.sel", 8'(pattern_sel), 8'd0);
      chk("post_rst.state", 8'(seq_state), 8'd0);
      repeat (IDLE) @(negedge clock);
      chk("auto_again.state", 8'(seq_state), 8'd1);

      // auto_f drops on the same edge as an advancing tick.
      run_frame(2'd2, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, "arm");
      @(negedge clock); auto_en = 1'b0;
      repeat (LAT) @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      chk("simul.sel", 8'(pattern_sel), 8'd1);
      chk("simul.state", 8'(seq_state), 8'd0);
      run_frame(2'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, "after_simul");

`ifdef SEQ_DEBOUNCE_EN
      // A glitch one cycle shorter than DEB_CYCLES must be filtered out.
      @(negedge clock); switch = 2'd0;
      repeat (DEB - 1) @(negedge clock);
      switch = 2'd2;
      repeat (IDLE) @(negedge clock);
      run_frame(2'd2, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, "glitch");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
